// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and FSM state encoding for the 8x8 matrix-multiply controller.
package matmul_pkg;
    localparam int DIM    = 8;
    localparam int ADDR_W = 6;
    localparam int ACC_W  = 19;
    localparam int CNT_W  = 11;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;
endpackage

// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: i/j/k loop counters and RAM A/B address generation, k innermost.
module matmul_addr_gen #(
    parameter int DIM = matmul_pkg::DIM
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_clr,
    input  logic                          i_en,
    output logic [2:0]                    o_k,
    output logic [matmul_pkg::ADDR_W-1:0] o_addr_a,
    output logic [matmul_pkg::ADDR_W-1:0] o_addr_b,
    output logic [matmul_pkg::ADDR_W-1:0] o_ij,
    output logic                          o_last
);
    import matmul_pkg::*;
    localparam logic [2:0] MAX = 3'(DIM - 1);
    logic [2:0] r_i, r_j, r_k;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_en) begin
            r_k <= r_k + 3'd1;
            if (r_k == MAX) r_j <= r_j + 3'd1;
            if (r_k == MAX && r_j == MAX) r_i <= r_i + 3'd1;
        end
    end
    assign o_k      = r_k;
    assign o_addr_a = {r_k, r_j};
    assign o_addr_b = {r_i, r_k};
    assign o_ij     = {r_i, r_j};
    assign o_last   = r_i == MAX && r_j == MAX && r_k == MAX;
endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequences one 8x8 multiply over external RAMs and MAC; owns the FSM,
// the read->MAC->write delay pipeline and the job cycle counter.
module matmul_ctrl #(
    parameter int DIM   = matmul_pkg::DIM,
    parameter int CNT_W = matmul_pkg::CNT_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    output logic                          rd_en,
    output logic [matmul_pkg::ADDR_W-1:0] addr_a,
    output logic [matmul_pkg::ADDR_W-1:0] addr_b,
    output logic                          mac_en,
    output logic                          mac_clr,
    output logic                          wr_en,
    output logic [matmul_pkg::ADDR_W-1:0] addr_c,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              clock_count
);
    import matmul_pkg::*;
    localparam logic [2:0] K_MAX = 3'(DIM - 1);
    state_t r_state, w_next;
    logic w_accept, w_last;
    logic [2:0] w_k;
    logic [ADDR_W-1:0] w_ij, r_ij_d1, r_addr_c;
    logic r_mac_en, r_mac_clr, r_wr_d1, r_wr_en;
    logic [CNT_W-1:0] r_cnt;

    matmul_addr_gen #(.DIM(DIM)) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_accept),
        .i_en     (rd_en),
        .o_k      (w_k),
        .o_addr_a (addr_a),
        .o_addr_b (addr_b),
        .o_ij     (w_ij),
        .o_last   (w_last)
    );

    always_comb begin
        w_next   = r_state;
        rd_en    = r_state == RUN;
        busy     = r_state == RUN || r_state == DRAIN1 || r_state == DRAIN2;
        done     = r_state == DONE;
        w_accept = start && (r_state == IDLE || r_state == DONE);
        case (r_state)
            IDLE, DONE: w_next = start ? RUN : r_state;
            RUN:        w_next = w_last ? DRAIN1 : RUN;
            DRAIN1:     w_next = DRAIN2;
            DRAIN2:     w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    // MAC sees read data one cycle after the read; the write follows the last accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
            r_wr_d1   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_ij_d1   <= '0;
            r_addr_c  <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_mac_en  <= rd_en;
            r_mac_clr <= rd_en && w_k == 3'd0;
            r_wr_d1   <= rd_en && w_k == K_MAX;
            r_wr_en   <= r_wr_d1;
            r_ij_d1   <= w_ij;
            r_addr_c  <= r_ij_d1;
            r_cnt     <= w_accept ? '0 : (busy && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    assign mac_en      = r_mac_en;
    assign mac_clr     = r_mac_clr;
    assign wr_en       = r_wr_en;
    assign addr_c      = r_addr_c;
    assign clock_count = r_cnt;
endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: directed bench with behavioural RAMs and MAC around matmul_ctrl.
module tb_matmul_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, start;
    logic        rd_en, mac_en, mac_clr, wr_en, busy, done;
    logic [5:0]  addr_a, addr_b, addr_c;
    logic [10:0] clock_count;
    logic signed [18:0] ram_a [64];
    logic signed [18:0] ram_b [64];
    logic signed [18:0] ram_c [64];
    int                 ram_tag [64];
    logic signed [18:0] q_a, q_b, acc;
    int job = 0, wr_cnt = 0, wr_base = 0, addr_bad = 0;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    matmul_ctrl #(.DIM(8), .CNT_W(11)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rd_en       (rd_en),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .mac_en      (mac_en),
        .mac_clr     (mac_clr),
        .wr_en       (wr_en),
        .addr_c      (addr_c),
        .busy        (busy),
        .done        (done),
        .clock_count (clock_count)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            q_a <= ram_a[addr_a];
            q_b <= ram_b[addr_b];
        end
        if (mac_en) acc <= mac_clr ? q_a * q_b : acc + q_a * q_b;
        if (wr_en) begin
            ram_c[addr_c]   <= acc;
            ram_tag[addr_c] <= job;
            if (addr_c != 6'(wr_cnt - wr_base)) addr_bad <= addr_bad + 1;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 1);
    endtask

    task automatic check_ram();
        int bad = 0;
        for (int n = 0; n < 64; n++)
            if (ram_tag[n] != job || ram_c[n] !== 19'(n - 32)) bad++;
        check("ram_c_bad", bad, 0);
        check("wr_count", wr_cnt - wr_base, 64);
        check("addr_c_order", addr_bad, 0);
    endtask

    task automatic launch(input int hold);
        job++;
        wr_base = wr_cnt;
        start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        for (int n = 0; n < 64; n++) begin
            ram_a[n]   = (n % 8 == n / 8) ? 19'sd1 : 19'sd0;
            ram_b[n]   = 19'(n - 32);
            ram_tag[n] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_mac", {mac_en, mac_clr, wr_en}, 0);
        check("rst_flags", {busy, done}, 0);
        check("rst_addr", {addr_a, addr_b, addr_c}, 0);
        check("rst_count", 32'(clock_count), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("wr_after_rst", 32'(wr_en), 0);

        launch(1);
        check("r1_rd_en", 32'(rd_en), 1);
        check("r1_addr", {addr_a, addr_b}, 0);
        check("r1_busy_done", {busy, done}, 2'b10);
        check("r1_count", 32'(clock_count), 0);
        for (int c = 2; c <= 515; c++) begin
            @(negedge clk);
            case (c)
                2:   check("r2_mac", {mac_en, mac_clr}, 2'b11);
                3:   check("r3_mac", {mac_en, mac_clr}, 2'b10);
                9:   check("r9_addr", {addr_a, addr_b}, {6'd1, 6'd0});
                65:  check("r65_addr", {addr_a, addr_b}, {6'd0, 6'd8});
                512: check("r512_addr", {rd_en, addr_a, addr_b}, {1'b1, 6'd63, 6'd63});
                513: check("drain1", {rd_en, mac_en, wr_en, busy}, 4'b0101);
                514: check("drain2", {wr_en, addr_c, done, busy}, {1'b1, 6'd63, 1'b0, 1'b1});
                515: check("done1", {done, busy, wr_en}, 3'b100);
                default: ;
            endcase
        end
        check("job1_count", 32'(clock_count), 514);
        check_ram();

        launch(100);
        wait_done(600);
        check("job2_count", 32'(clock_count), 514);
        check_ram();

        launch(1);
        check("restart", {done, busy, rd_en}, 3'b011);
        check("restart_count", 32'(clock_count), 0);
        repeat (199) @(negedge clk);
        check("r200_busy", {busy, mac_en}, 2'b11);
        reset_n = 1'b0;
        #1;
        check("arst_strobes", {rd_en, mac_en, mac_clr, wr_en}, 0);
        check("arst_flags", {busy, done}, 0);
        check("arst_addr", {addr_a, addr_b, addr_c}, 0);
        check("arst_count", 32'(clock_count), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_idle", {wr_en, busy, done}, 0);

        launch(1);
        wait_done(600);
        check("job4_count", 32'(clock_count), 514);
        check_ram();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
